// File: rtl/apb_master.sv
// APB initiator: takes one command per handshake, runs SETUP/ACCESS on the APB link,
// and returns read data / error status; a wait-state watchdog bounds a silent slave.
module apb_master #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PWRITE,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    // state  | meaning
    // IDLE   | cmd_ready high, waiting for a command
    // SETUP  | PSEL high, PENABLE low, one cycle
    // ACCESS | PSEL/PENABLE high, waiting for PREADY or watchdog
    // RESP   | response held until consumed
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int unsigned CW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned TC_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [CW-1:0] WD_LAST = CW'(TC_LAST);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  pwrite_q, pwrite_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [CW-1:0]         wd_cnt_q, wd_cnt_d;
    logic                  wd_expired;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            wd_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            wd_cnt_q    <= wd_cnt_d;
        end
    end

    // A zero TIMEOUT_CYCLES disables the watchdog entirely.
    assign wd_expired = (TIMEOUT_CYCLES != 0) && (wd_cnt_q == WD_LAST);

    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        wd_cnt_d    = wd_cnt_q;
        cmd_ready   = 1'b0;

        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    pwrite_d = cmd_write;
                    psel_d   = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                wd_cnt_d  = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // PREADY on the watchdog's last cycle still completes normally.
                if (PREADY) begin
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                    rsp_err_d   = PSLVERR;
                    rsp_valid_d = 1'b1;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    state_d     = RESP;
                end else if (wd_expired) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    state_d     = RESP;
                end else begin
                    wd_cnt_d = wd_cnt_q + CW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PWRITE    = pwrite_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: a behavioural APB slave with programmable wait states,
// hand-computed expected responses, stall/back-pressure and mid-transfer reset.
module tb_apb_master;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA = '0;
    logic        PREADY = 1'b0;
    logic        PSLVERR = 1'b0;

    int checks = 0;
    int errors = 0;
    int acc;

    apb_master #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .PADDR    (PADDR),
        .PWRITE   (PWRITE),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one command at the current negedge, play the slave with `waits` wait
    // states (-1 = never ready), and return at the negedge where rsp_valid is high.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int waits, input logic [31:0] rdata, input logic err,
                        output int n_acc);
        logic done;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        cmd_write = ~wr;
        cmd_addr  = ~addr;
        cmd_wdata = ~wdata;
        chk("setup_psel_penable", 32'({PSEL, PENABLE}), 32'b10);
        chk("setup_paddr", PADDR, addr);
        chk("setup_pwdata", PWDATA, wdata);
        chk("setup_pwrite", 32'(PWRITE), 32'(wr));
        chk("setup_cmd_ready", 32'(cmd_ready), 32'd0);
        // Junk presented during SETUP must be ignored.
        PREADY  = 1'b1;
        PSLVERR = 1'b1;
        PRDATA  = 32'hBAD0_0001;
        n_acc = 0;
        done  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge PCLK);
            if (rsp_valid) begin
                done = 1'b1;
                break;
            end
            n_acc++;
            chk("acc_sel_en_wr", 32'({PSEL, PENABLE, PWRITE}), 32'({2'b11, wr}));
            chk("acc_paddr", PADDR, addr);
            chk("acc_pwdata", PWDATA, wdata);
            PREADY  = (waits >= 0) && (n_acc > waits);
            PRDATA  = PREADY ? rdata : 32'h5A5A_5A5A;
            PSLVERR = PREADY ? err : 1'b0;
        end
        chk("rsp_arrives", 32'(done), 32'd1);
        chk("resp_psel_penable", 32'({PSEL, PENABLE}), 32'b00);
        chk("resp_cmd_ready", 32'(cmd_ready), 32'd0);
        // Junk in RESP must be ignored as well.
        PREADY  = 1'b1;
        PRDATA  = 32'hBAD0_0002;
        PSLVERR = 1'b1;
    endtask

    // Hold off rsp_ready for `stall` cycles while a new command waits, then consume.
    task automatic take(input int stall);
        logic [31:0] r;
        logic        e;
        r = rsp_rdata;
        e = rsp_err;
        for (int i = 0; i < stall; i++) begin
            cmd_valid = 1'b1;
            cmd_write = 1'b1;
            cmd_addr  = 32'h0000_0FF0;
            @(negedge PCLK);
            chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("stall_rdata", rsp_rdata, r);
            chk("stall_err", 32'(rsp_err), 32'(e));
            chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("stall_psel", 32'(PSEL), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge PCLK);
        chk("take_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("take_no_accept", 32'(PSEL), 32'd0);
        chk("take_cmd_ready", 32'(cmd_ready), 32'd1);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=%h expected=%h", 32'd0, 32'd1);
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        // Reset values.
        #12;
        chk("rst_psel_penable", 32'({PSEL, PENABLE, PWRITE}), 32'd0);
        chk("rst_paddr", PADDR, 32'd0);
        chk("rst_pwdata", PWDATA, 32'd0);
        chk("rst_rsp", 32'({rsp_valid, rsp_err}), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);

        // 1. Zero-wait write: rdata forced to 0 despite PRDATA junk.
        xfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h1234_5678, 1'b0, acc);
        chk("t1_acc_cycles", 32'(acc), 32'd1);
        chk("t1_rdata", rsp_rdata, 32'd0);
        chk("t1_err", 32'(rsp_err), 32'd0);
        take(0);

        // 2. Read with 3 wait states; PREADY lands on the watchdog's final cycle and wins.
        xfer(1'b0, 32'h0000_0010, 32'h0, 3, 32'hDEAD_BEEF, 1'b0, acc);
        chk("t2_acc_cycles", 32'(acc), 32'd4);
        chk("t2_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk("t2_err", 32'(rsp_err), 32'd0);
        // 5. Back-pressure on the response for 5 cycles.
        take(5);

        // 3. Slave error, then a clean follow-up.
        xfer(1'b0, 32'h0000_0024, 32'h0, 1, 32'hCAFE_F00D, 1'b1, acc);
        chk("t3_acc_cycles", 32'(acc), 32'd2);
        chk("t3_rdata", rsp_rdata, 32'hCAFE_F00D);
        chk("t3_err", 32'(rsp_err), 32'd1);
        take(1);
        xfer(1'b0, 32'h0000_0028, 32'h0, 0, 32'h0BAD_CAFE, 1'b0, acc);
        chk("t3b_rdata", rsp_rdata, 32'h0BAD_CAFE);
        chk("t3b_err", 32'(rsp_err), 32'd0);
        take(0);

        // 4. Silent slave: watchdog fires after exactly 4 ACCESS cycles.
        xfer(1'b0, 32'h0000_0030, 32'h0, -1, 32'h0, 1'b0, acc);
        chk("t4_acc_cycles", 32'(acc), 32'd4);
        chk("t4_rdata", rsp_rdata, 32'd0);
        chk("t4_err", 32'(rsp_err), 32'd1);
        take(2);

        // 6. Reset asserted during ACCESS.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0000_0040;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        PREADY    = 1'b0;
        @(negedge PCLK);
        chk("t6_in_access", 32'({PSEL, PENABLE}), 32'b11);
        #2;
        PRESETn = 1'b0;
        #1;
        chk("t6_async_drop", 32'({PSEL, PENABLE}), 32'b00);
        chk("t6_no_rsp", 32'(rsp_valid), 32'd0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            chk("t6_quiet", 32'({rsp_valid, PSEL}), 32'd0);
        end
        xfer(1'b1, 32'h0000_0044, 32'h1357_9BDF, 0, 32'h0, 1'b0, acc);
        chk("t6_write_err", 32'(rsp_err), 32'd0);
        chk("t6_write_rdata", rsp_rdata, 32'd0);
        take(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
